// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared opcodes, FSM encoding and widths for the ALU arbiter
package ula_pkg;

    localparam int DATA_W = 4;
    localparam int SEL_W  = 3;

    typedef enum logic [SEL_W-1:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_NOT  = 3'b010,
        OP_NAND = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Codes 110 and 111 have no operation behind them.
    function automatic logic is_unsupported(input logic [SEL_W-1:0] sel);
        return (sel[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/ula.sv
// rtl/ula.sv - 4-bit combinational ALU, modulo-16 arithmetic, zero for unsupported codes
module ula
    import ula_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [SEL_W-1:0]  seletor,
    output logic [DATA_W-1:0] resultado
);

    always_comb begin
        resultado = '0;
        case (seletor)
            OP_AND:  resultado = a & b;
            OP_OR:   resultado = a | b;
            OP_NOT:  resultado = ~a;
            OP_NAND: resultado = ~(a & b);
            OP_ADD:  resultado = a + b;
            OP_SUB:  resultado = a - b;
            default: resultado = '0;
        endcase
    end

endmodule

// File: rtl/ula_arbitro.sv
// rtl/ula_arbitro.sv - two-requester arbiter sharing one ALU with a registered response channel
module ula_arbitro
    import ula_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [SEL_W-1:0]  req0_seletor,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [SEL_W-1:0]  req1_seletor,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resultado,
    output logic              resp_zero,
    output logic              resp_erro,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    state_e              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                id_q, id_d;
    logic [DATA_W-1:0]   resultado_q, resultado_d;
    logic                zero_q, zero_d;
    logic                erro_q, erro_d;
    logic                resp_id_q, resp_id_d;
    logic                resp_valid_q, resp_valid_d;
    logic [CNT_W-1:0]    cnt0_q, cnt0_d;
    logic [CNT_W-1:0]    cnt1_q, cnt1_d;

    logic                grant0;
    logic                grant1;
    logic                accept;
    logic [DATA_W-1:0]   alu_res;

    // ptr_q==0 favours requester 0 on a conflict; FIXED_PRIO pins it there.
    assign grant0 = req0_valid & (~req1_valid | ~ptr_q | (FIXED_PRIO != 0));
    assign grant1 = req1_valid & ~grant0;
    assign accept = (state_q == ST_IDLE) & (grant0 | grant1);

    ula u_ula (
        .a         (a_q),
        .b         (b_q),
        .seletor   (sel_q),
        .resultado (alu_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= '0;
            id_q         <= 1'b0;
            resultado_q  <= '0;
            zero_q       <= 1'b0;
            erro_q       <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sel_q        <= sel_d;
            id_q         <= id_d;
            resultado_q  <= resultado_d;
            zero_q       <= zero_d;
            erro_q       <= erro_d;
            resp_id_q    <= resp_id_d;
            resp_valid_q <= resp_valid_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (resp_valid_q && resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state_q == ST_IDLE) & grant0;
        req1_ready = (state_q == ST_IDLE) & grant1;
        resp_valid = resp_valid_q;
        resp_id    = resp_id_q;
        resultado  = resultado_q;
        resp_zero  = zero_q;
        resp_erro  = erro_q;
        cnt0       = cnt0_q;
        cnt1       = cnt1_q;
    end

    always_comb begin
        ptr_d        = ptr_q;
        a_d          = a_q;
        b_d          = b_q;
        sel_d        = sel_q;
        id_d         = id_q;
        resultado_d  = resultado_q;
        zero_d       = zero_q;
        erro_d       = erro_q;
        resp_id_d    = resp_id_q;
        resp_valid_d = resp_valid_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d   = grant1 ? req1_a       : req0_a;
                    b_d   = grant1 ? req1_b       : req0_b;
                    sel_d = grant1 ? req1_seletor : req0_seletor;
                    id_d  = grant1;
                    ptr_d = ~grant1;
                end
            end
            ST_EXEC: begin
                resultado_d  = alu_res;
                zero_d       = (alu_res == '0);
                erro_d       = is_unsupported(sel_q);
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
            end
            ST_RESP: begin
                if (resp_valid_q && resp_ready) begin
                    resp_valid_d = 1'b0;
                    if (resp_id_q) cnt1_d = cnt1_q + CNT_W'(1);
                    else           cnt0_d = cnt0_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/ula_arbitro.md
Name: ula_arbitro

Overview:
- Shares one instance of the team's 4-bit combinational ALU (`ula`) between two requesters, using round-robin arbitration (fixed priority optional).
- Each operation is captured, executed and returned through a registered response channel, with valid/ready handshakes on every side.
- Sits between two control masters (e.g. sequencer and test/debug port) and the single ALU datapath.
- Also counts completed operations per requester.

Parameters:
- FIXED_PRIO, 0, 1 = requester 0 always wins a conflict; 0 = round-robin.
- CNT_W, 8, width of each completed-operation counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 presents an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  4  operand A, requester 0.
- req0_b  in  4  operand B, requester 0.
- req0_seletor  in  3  operation code, requester 0.
- req1_valid / req1_ready / req1_a / req1_b / req1_seletor  same as requester 0, for requester 1.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes the response.
- resp_id  out  1  requester that issued the operation.
- resultado  out  4  ALU result.
- resp_zero  out  1  resultado == 0.
- resp_erro  out  1  seletor was 110 or 111 (unsupported code).
- cnt0  out  CNT_W  responses delivered to requester 0.
- cnt1  out  CNT_W  responses delivered to requester 1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ptr=0 (requester 0 favoured first), all captured operand/result registers 0, resp_valid=0, resp_id=0, resultado=0, resp_zero=0, resp_erro=0, cnt0=cnt1=0.
  - Reset mid-operation discards the in-flight operation; nothing is delivered and no counter moves.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational. grant0 = req0_valid & (~req1_valid | ptr==0 | FIXED_PRIO). grant1 = req1_valid & ~grant0.
  - reqN_ready = (state==IDLE) & grantN. ready is never asserted outside IDLE.
  - On valid&ready: capture a, b, seletor and id into registers; ptr <= ~id; go to EXEC.
- EXEC (one cycle):
  - Registered operands drive the `ula` instance.
  - On the edge: resultado <= ALU output, resp_zero <= (ALU output==0), resp_erro <= (seletor[2:1]==2'b11), resp_id <= id, resp_valid <= 1; go to RESP.
- RESP:
  - resultado, resp_id, resp_zero and resp_erro are held stable while resp_valid=1 & resp_ready=0.
  - On resp_valid & resp_ready: resp_valid <= 0, cnt[resp_id] increments, go to IDLE.
- Latency: accept edge N, resp_valid high after edge N+1, earliest accept of the next op in the cycle after the response handshake. Minimum 3 cycles per operation; no pipelining.
- Arithmetic:
  - Modulo 2^4, no carry/borrow output. Example: 3-5 = 4'hE.
  - Unsupported seletor gives resultado=0 with resp_erro=1 and resp_zero=1. It is still counted.
- Counters wrap from 2^CNT_W-1 to 0 without saturation.
- Requester rules:
  - A requester may drop valid before ready without penalty; no grant is latched.
  - Operand changes while valid=1 and ready=0 are allowed. The values sampled on the accept edge are used.
- Arbitration fairness: round-robin with both valid continuously gives the strict alternation 0,1,0,1…; ptr is updated only on accept.

Decomposition:
- Shared package `ula_pkg`:
  - Operation codes OP_AND=000, OP_OR=001, OP_NOT=010, OP_NAND=011, OP_ADD=100, OP_SUB=101.
  - FSM state encoding (IDLE, EXEC, RESP, 2 bits).
- Sub-module: the existing `ula` combinational unit, instantiated once. Arbitration, FSM and counters live in ula_arbitro.

Test Plan:
- Reset, then req0 a=5 b=3 seletor=100 with resp_ready=1 → req0_ready high 1 cycle; two cycles later resp_valid=1, resultado=8, resp_id=0, resp_zero=0; cnt0=1.
- req1 a=3 b=5 seletor=101 → resultado=4'hE, resp_id=1. Then a=4'hA b=4'h5 seletor=000 → resultado=0, resp_zero=1.
- Both valid continuously for 4 ops, FIXED_PRIO=0 → resp_id order 0,1,0,1; cnt0=cnt1=2. Repeat with FIXED_PRIO=1 → 0,0,0,0.
- resp_ready=0 for 5 cycles after resp_valid → resultado/resp_id held stable, both ready low, no counter change. Then resp_ready=1 → single handshake, counter +1.
- seletor=111 from req0 → resultado=0, resp_erro=1, resp_zero=1, cnt0 increments.
- rst_n low mid-EXEC → all outputs immediately 0, resp_valid never asserted for that op. After release, req0 gets the first grant when both are valid.
